// File: rtl/muldiv_pkg.sv
// Shared encodings for the M-extension unit: funct3 ops, FSM states, ALUOp selector.
// Pure declarations: no latency, no flow control.
// Imported by the decoder, the hazard unit and the multiply/divide datapath.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

  // ALU_MULDIV routes an R-type instruction with funct7=0000001 to rv_muldiv.
  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_FUNCT  = 2'b10,
    ALU_MULDIV = 2'b11
  } alu_op_e;

  function automatic logic md_is_div(input logic [2:0] f);
    return f[2];
  endfunction

  function automatic logic md_is_rem(input logic [2:0] f);
    return f[2] & f[1];
  endfunction

endpackage

// File: rtl/rv_muldiv_if.sv
// EX-stage request/response bundle between the pipeline and rv_muldiv.
// Wires only: no latency; the pipeline stalls on busy | (start & ~done).
// master = pipeline side, slave = multiply/divide unit.
interface rv_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, op_a, op_b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, op_a, op_b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_signfix.sv
// Operand magnitude/sign extraction and final conditional negation for rv_muldiv.
// Combinational, zero latency; no flow control.
// The negate-result flag follows the remainder-takes-dividend-sign rule.
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic [XLEN-1:0]   mag_a,
  output logic [XLEN-1:0]   mag_b,
  output logic              neg_res,
  input  logic [2*XLEN-1:0] raw,
  input  logic              raw_neg,
  output logic [2*XLEN-1:0] fixed
);

  logic a_signed;
  logic b_signed;
  logic sign_a;
  logic sign_b;

  always_comb begin
    a_signed = 1'b1;
    b_signed = 1'b1;
    unique case (md_op_e'(funct3))
      MD_MULHSU:                  b_signed = 1'b0;
      MD_MULHU, MD_DIVU, MD_REMU: begin
        a_signed = 1'b0;
        b_signed = 1'b0;
      end
      default: ;
    endcase
  end

  assign sign_a  = a_signed & op_a[XLEN-1];
  assign sign_b  = b_signed & op_b[XLEN-1];
  assign mag_a   = sign_a ? -op_a : op_a;
  assign mag_b   = sign_b ? -op_b : op_b;
  assign neg_res = md_is_rem(funct3) ? sign_a : (sign_a ^ sign_b);

  // Negating the full 2*XLEN value keeps MULH* high halves correct.
  assign fixed   = raw_neg ? -raw : raw;

endmodule

// File: rtl/rv_muldiv.sv
// Iterative RV32M/RV64M multiply/divide: shift-add multiplier, restoring divider.
// Latency XLEN+1 cycles (1 for divide-by-zero / signed overflow); one-cycle done pulse.
// No internal queue: start is ignored while busy, flush aborts to IDLE without done.
module rv_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          reset,
  rv_muldiv_if.slave   md
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  md_state_e         state;
  md_state_e         state_d;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   result_q;

  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              neg_res;
  logic [2*XLEN-1:0] fix_in;
  logic [2*XLEN-1:0] fix_out;
  logic [XLEN-1:0]   final_val;

  logic              launch;
  logic              last;
  logic              div_zero;
  logic              div_ovf;
  logic              special;
  logic [XLEN-1:0]   special_val;
  logic [XLEN:0]     div_cand;
  logic [XLEN:0]     div_trial;
  logic [XLEN:0]     mul_sum;

  muldiv_signfix #(.XLEN(XLEN)) u_signfix (
    .funct3  (md.funct3),
    .op_a    (md.op_a),
    .op_b    (md.op_b),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .neg_res (neg_res),
    .raw     (fix_in),
    .raw_neg (neg_q),
    .fixed   (fix_out)
  );

  assign launch   = (state != CALC) && md.start && !md.flush;
  assign last     = (state == CALC) && (cnt == CNT_W'(XLEN - 1));
  assign div_zero = md_is_div(md.funct3) && (md.op_b == '0);
  assign div_ovf  = ((md.funct3 == MD_DIV) || (md.funct3 == MD_REM)) &&
                    (md.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (md.op_b == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_val = '0;
    if (div_zero)
      special_val = md_is_rem(md.funct3) ? md.op_a : '1;
    else if (div_ovf)
      special_val = md_is_rem(md.funct3) ? '0 : md.op_a;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE, DONE: begin
        if (md.start) state_d = special ? DONE : CALC;
        else          state_d = IDLE;
      end
      CALC:    if (last) state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (md.flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // acc is {partial product, multiplier} for MUL*, {remainder, quotient} for DIV/REM.
  always_comb begin
    div_cand  = acc[2*XLEN-1:XLEN-1];
    div_trial = div_cand - {1'b0, opnd_q};
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_q} : '0);
    acc_next  = '0;
    if (md_is_div(op_q)) begin
      if (!div_trial[XLEN]) acc_next = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else                  acc_next = {div_cand[XLEN-1:0],  acc[XLEN-2:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc[XLEN-1:1]};
    end
  end

  always_comb begin
    fix_in = acc_next;
    if (md_is_div(op_q))
      fix_in = md_is_rem(op_q) ? {{XLEN{1'b0}}, acc_next[2*XLEN-1:XLEN]}
                               : {{XLEN{1'b0}}, acc_next[XLEN-1:0]};
    if (md_is_div(op_q) || (op_q == MD_MUL)) final_val = fix_out[XLEN-1:0];
    else                                     final_val = fix_out[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc      <= '0;
      result_q <= '0;
    end else if (launch) begin
      cnt    <= '0;
      op_q   <= md.funct3;
      neg_q  <= neg_res;
      opnd_q <= mag_b;
      acc    <= {{XLEN{1'b0}}, mag_a};
      if (special) result_q <= special_val;
    end else if ((state == CALC) && !md.flush) begin
      acc <= acc_next;
      cnt <= cnt + CNT_W'(1);
      if (last) result_q <= final_val;
    end
  end

  assign md.busy   = (state == CALC);
  assign md.done   = (state == DONE);
  assign md.result = result_q;

endmodule
